// File: rtl/xor_chk_pkg.sv
// Shared types for the XOR parity checker: FSM state encoding and the
// registered result record presented on the output handshake.
package xor_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } xor_chk_state_t;

  // len is sized for the widest supported count; instances use the low CNT_W bits.
  localparam int RES_LEN_W = 16;

  typedef struct packed {
    logic                 err;
    logic [RES_LEN_W-1:0] len;
    logic                 ovf;
  } result_t;

endpackage

// File: rtl/xor_parity_checker.sv
// Receive-side XOR parity checker: accumulates frame parity over a beat stream
// and reports error/length/overflow through a one-entry result handshake.
//
// state  | meaning
// IDLE   | no beat of the current frame taken yet
// ACCUM  | at least one beat taken, last beat not seen yet
// REPORT | result held until the consumer takes it
module xor_parity_checker
  import xor_chk_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_parity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_err,
  output logic [CNT_W-1:0]  out_len,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  xor_chk_state_t   state_q;
  logic             acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  result_t          res_q;

  logic             beat_ok;
  logic             res_taken;
  logic             at_max;
  logic             acc_nxt;
  logic [CNT_W-1:0] cnt_inc;

  assign out_valid = (state_q == REPORT);
  assign in_ready  = !out_valid;
  assign beat_ok   = in_valid && in_ready;
  assign res_taken = out_valid && out_ready;

  // Count saturates rather than wraps; hitting the ceiling again flags overflow.
  assign at_max  = (cnt_q == CNT_MAX);
  assign cnt_inc = at_max ? cnt_q : cnt_q + 1'b1;
  assign acc_nxt = acc_q ^ (^in_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (beat_ok) begin
            if (in_last) begin
              res_q.err <= acc_nxt ^ in_parity;
              res_q.len <= RES_LEN_W'(cnt_inc);
              res_q.ovf <= ovf_q | at_max;
              acc_q     <= 1'b0;
              cnt_q     <= '0;
              ovf_q     <= 1'b0;
              state_q   <= REPORT;
            end else begin
              acc_q   <= acc_nxt;
              cnt_q   <= cnt_inc;
              ovf_q   <= ovf_q | at_max;
              state_q <= ACCUM;
            end
          end
        end
        REPORT: begin
          if (res_taken) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_err = res_q.err;
  assign out_len = CNT_W'(res_q.len);
  assign out_ovf = res_q.ovf;

endmodule

// File: tb/tb_xor_parity_checker.sv
// Directed, table-driven bench for xor_parity_checker with hand-computed results.
module tb_xor_parity_checker;

  localparam int DATA_W    = 8;
  localparam int MAX_BEATS = 16;
  localparam int CNT_W     = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              in_parity = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_err;
  logic [CNT_W-1:0]  out_len;
  logic              out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  xor_parity_checker #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_parity (in_parity),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err),
    .out_len   (out_len),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              n;
    logic [3:0][7:0] d;
    logic            par;
    logic            err;
    int              len;
    logic            ovf;
    string           name;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input int n, input logic [31:0] d, input logic par,
                              input logic err, input int len, input logic ovf,
                              input string name);
    vec_t v;
    v.n = n; v.d = d; v.par = par; v.err = err; v.len = len; v.ovf = ovf; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [7:0] d, input logic last, input logic par,
                           input string tag);
    int w;
    w = 0;
    in_valid = 1'b1; in_data = d; in_last = last; in_parity = par;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic err, input int len, input logic ovf);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " out_err"},   32'(out_err),   32'(err));
    check({tag, " out_len"},   32'(out_len),   32'(len));
    check({tag, " out_ovf"},   32'(out_ovf),   32'(ovf));
  endtask

  task automatic check_idle(input string tag);
    check({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " idle in_ready"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(1, 32'h00000003, 1'b0, 1'b0, 1, 1'b0, "single_03");
    vecs[1] = mk(1, 32'h00000001, 1'b0, 1'b1, 1, 1'b0, "single_01_err");
    vecs[2] = mk(3, 32'h00040201, 1'b1, 1'b0, 3, 1'b0, "three_beat");
    vecs[3] = mk(4, 32'h00010FFF, 1'b1, 1'b0, 4, 1'b0, "four_beat");
    vecs[4] = mk(2, 32'h00008080, 1'b1, 1'b1, 2, 1'b0, "two_beat_err");
    vecs[5] = mk(1, 32'h00000080, 1'b1, 1'b0, 1, 1'b0, "single_80");

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_err",   32'(out_err),   32'd0);
    check("reset out_len",   32'(out_len),   32'd0);
    check("reset out_ovf",   32'(out_ovf),   32'd0);
    check("reset in_ready",  32'(in_ready),  32'd1);

    // Table-driven frames, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < vecs[i].n; b++)
        send_beat(vecs[i].d[b], (b == vecs[i].n - 1), vecs[i].par, vecs[i].name);
      check_result(vecs[i].name, vecs[i].err, vecs[i].len, vecs[i].ovf);
      step();
      check_idle(vecs[i].name);
    end

    // Backpressure: result held while producer waits with a pending beat
    out_ready = 1'b0;
    send_beat(8'h03, 1'b1, 1'b1, "bp_first");
    in_valid = 1'b1; in_data = 8'h05; in_last = 1'b1; in_parity = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_result("bp_hold", 1'b1, 1, 1'b0);
      check("bp_hold in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check_idle("bp_release");
    out_ready = 1'b0;
    step();
    check_result("bp_second", 1'b0, 1, 1'b0);
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    step();
    check_idle("bp_second");

    // Exactly MAX_BEATS beats: no overflow
    for (int b = 0; b < 16; b++)
      send_beat(8'h00, (b == 15), 1'b0, "len16");
    check_result("len16", 1'b0, 16, 1'b0);
    step();

    // MAX_BEATS+1 beats: saturate and flag overflow
    for (int b = 0; b < 17; b++)
      send_beat(8'h00, (b == 16), 1'b0, "len17");
    check_result("len17", 1'b0, 16, 1'b1);
    step();

    // Reset mid-frame discards the partial frame
    send_beat(8'h01, 1'b0, 1'b0, "rst_mid");
    send_beat(8'h03, 1'b0, 1'b0, "rst_mid");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid out_valid", 32'(out_valid), 32'd0);
    check("rst_mid out_err",   32'(out_err),   32'd0);
    check("rst_mid out_len",   32'(out_len),   32'd0);
    check("rst_mid out_ovf",   32'(out_ovf),   32'd0);
    check("rst_mid in_ready",  32'(in_ready),  32'd1);
    send_beat(8'h80, 1'b1, 1'b1, "after_rst");
    check_result("after_rst", 1'b0, 1, 1'b0);
    step();

    // Reset during REPORT, coinciding with the output handshake
    out_ready = 1'b0;
    send_beat(8'h01, 1'b1, 1'b0, "rst_report");
    check_result("rst_report", 1'b1, 1, 1'b0);
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0;
    check("rst_report out_err", 32'(out_err), 32'd0);
    check_idle("rst_report");
    send_beat(8'h07, 1'b1, 1'b1, "after_rst_report");
    check_result("after_rst_report", 1'b0, 1, 1'b0);
    step();
    check_idle("after_rst_report");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_parity_checker.md
# xor_parity_checker

Receive-side counterpart of the team's XOR parity generator. It takes a beat-serial data stream under a valid/ready handshake and XOR-accumulates every data bit of a frame. On the last beat it compares the accumulated parity against the parity bit sent by the producer, then presents a one-entry result (error flag, beat count, overflow) under a second valid/ready handshake. It can be instantiated directly or attached with `bind` to any producer that drives the matching stream ports.

## Interface
- `DATA_W`, default 8: data bits per beat (≥1).
- `MAX_BEATS`, default 16: beat count saturation limit (≥1); `CNT_W = $clog2(MAX_BEATS+1)`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  producer has a beat.
- `in_ready`  out  1  checker accepts a beat.
- `in_data`  in  DATA_W  beat payload.
- `in_last`  in  1  final beat of frame.
- `in_parity`  in  1  expected even parity of the whole frame (XOR of all data bits); sampled only on the last beat.
- `out_valid`  out  1  result pending.
- `out_ready`  in  1  consumer takes result.
- `out_err`  out  1  parity mismatch.
- `out_len`  out  CNT_W  beats in frame, saturating at MAX_BEATS.
- `out_ovf`  out  1  frame exceeded MAX_BEATS beats.

## Operation
- States: IDLE (no beat of current frame yet), ACCUM (≥1 beat taken, no last yet), REPORT (result held).
- Beat accepted when `in_valid && in_ready`; `in_ready = !out_valid` (high in IDLE and ACCUM).
- Non-last beat:
  - `acc <= acc ^ (^in_data)`
  - `cnt <= min(cnt+1, MAX_BEATS)`
  - `ovf` sets if cnt is already MAX_BEATS.
  - IDLE→ACCUM, or stay in ACCUM.
- Last beat, from IDLE or ACCUM → REPORT:
  - `out_err <= acc ^ (^in_data) ^ in_parity`
  - `out_len <= min(cnt+1, MAX_BEATS)`
  - `out_ovf <= ovf | (cnt == MAX_BEATS)`
  - `acc`, `cnt` and `ovf` clear.
- A single-beat frame (IDLE with `in_last`) goes straight to REPORT.
- REPORT: outputs are held stable until `out_valid && out_ready`, then REPORT→IDLE.
- `in_valid` while in REPORT is ignored. The producer must hold its beat, per the handshake rules.
- `in_parity` on non-last beats is don't-care.
- Width rules:
  - `^in_data` is a 1-bit reduction.
  - `cnt` never wraps; it saturates at MAX_BEATS.

## Timing
- Reset (synchronous, active-high) forces these on the next edge:
  - state IDLE, `acc`/`cnt`/`ovf` 0.
  - outputs: `out_valid`=0, `out_err`=0, `out_len`=0, `out_ovf`=0.
  - `in_ready`=1.
- Latency: `out_valid` rises on the edge that accepts the last beat, i.e. the result is visible the following cycle.
- Throughput:
  - one beat per cycle within a frame.
  - between frames, the last-beat cycle is followed by at least one REPORT cycle with `in_ready`=0.
  - if `out_ready` is high in the first REPORT cycle, `in_ready` is high again the next cycle, so the best case is one bubble per frame.
- Reset mid-frame or mid-REPORT: the partial frame or pending result is discarded with no output, and the next frame is checked cleanly.
- Simultaneous reset and handshake: reset wins.

## Structure
- Package `xor_chk_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ACCUM, REPORT} xor_chk_state_t`
  - a `result_t` struct {err, len, ovf} (len width passed via parameterised use).
- Single module; no sub-module. The parity reduce is one expression, and the output register is a single `result_t`.
- The module must stay bind-compatible: port names match the generator's stream ports, so `.*` connection works.

## Test plan
- Single beat, `in_data`=8'h03, `in_parity`=0, `out_ready`=1 → next cycle `out_valid`=1, `out_err`=0, `out_len`=1, `out_ovf`=0; IDLE two cycles later.
- Single beat, `in_data`=8'h01, `in_parity`=0 → `out_err`=1, `out_len`=1.
- Three beats 8'h01, 8'h02, 8'h04 (last on the third), `in_parity`=1 → `out_err`=0, `out_len`=3; `in_ready` stays 1 during the frame.
- Backpressure: after the result, hold `out_ready`=0 for 5 cycles while the producer holds `in_valid`=1 → outputs stable, `in_ready`=0 throughout; first beat accepted the cycle after the `out_ready` handshake.
- MAX_BEATS=16, frame of 17 beats of 8'h00 with `in_parity`=0 → `out_len`=16, `out_ovf`=1, `out_err`=0.
- Assert `rst` for 1 cycle after 2 beats of a frame → all outputs 0. A following single beat 8'h80 with `in_parity`=1 → `out_err`=0, `out_len`=1.
